// File: rtl/alu_accumulator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : alu_accumulator
// Description : Accumulator/sequencer around an external carry-ripple adder.
//               Build option ALU_SUB_EN enables the SUB/SBC opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_accumulator #(
    parameter int DATA_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              op_valid_i,
    output logic              op_ready_o,
    input  logic [2:0]        op_code_i,
    input  logic [DATA_W-1:0] operand_i,
    output logic [DATA_W-1:0] add_a_o,
    output logic [DATA_W-1:0] add_b_o,
    output logic              add_carry_o,
    input  logic [DATA_W-1:0] add_sum_i,
    input  logic              add_carry_i,
    output logic [DATA_W-1:0] acc_o,
    output logic              flag_c_o,
    output logic              flag_z_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [2:0] c_OP_NOP = 3'b000;
    localparam logic [2:0] c_OP_LDA = 3'b001;
    localparam logic [2:0] c_OP_ADD = 3'b010;
    localparam logic [2:0] c_OP_ADC = 3'b011;
    localparam logic [2:0] c_OP_SUB = 3'b100;
    localparam logic [2:0] c_OP_SBC = 3'b101;
    localparam logic [2:0] c_OP_CLR = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_op_code;
    logic [DATA_W-1:0]   r_operand;
    logic [DATA_W-1:0]   r_acc_snap;
    logic [DATA_W-1:0]   r_acc;
    logic                r_c;
    logic                r_z;
    logic                r_err;

    logic                w_acc_we;
    logic [DATA_W-1:0]   w_acc_nxt;
    logic                w_c_we;
    logic                w_c_nxt;
    logic                w_illegal;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        op_ready_o  = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        case (r_state)
            S_IDLE: begin
                op_ready_o = 1'b1;
                if (op_valid_i) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done_o      = 1'b1;
                err_o       = r_err;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Result selection; opcodes without a case arm are illegal and write nothing.
    always_comb begin
        w_acc_we  = 1'b0;
        w_acc_nxt = r_acc;
        w_c_we    = 1'b0;
        w_c_nxt   = r_c;
        w_illegal = 1'b0;
        case (r_op_code)
            c_OP_NOP: begin
            end
            c_OP_LDA: begin
                w_acc_we  = 1'b1;
                w_acc_nxt = r_operand;
            end
            c_OP_ADD, c_OP_ADC
`ifdef ALU_SUB_EN
            , c_OP_SUB, c_OP_SBC
`endif
            : begin
                w_acc_we  = 1'b1;
                w_acc_nxt = add_sum_i;
                w_c_we    = 1'b1;
                w_c_nxt   = add_carry_i;
            end
            c_OP_CLR: begin
                w_acc_we  = 1'b1;
                w_acc_nxt = '0;
                w_c_we    = 1'b1;
                w_c_nxt   = 1'b0;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_op_code  <= c_OP_NOP;
            r_operand  <= '0;
            r_acc_snap <= '0;
            r_acc      <= '0;
            r_c        <= 1'b0;
            r_z        <= 1'b1;
            r_err      <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && op_valid_i) begin
                r_op_code  <= op_code_i;
                r_operand  <= operand_i;
                r_acc_snap <= r_acc;
            end
            if (r_state == S_EXEC) begin
                r_err <= w_illegal;
                if (w_acc_we) begin
                    r_acc <= w_acc_nxt;
                    r_z   <= (w_acc_nxt == '0);
                end
                if (w_c_we) begin
                    r_c <= w_c_nxt;
                end
            end
        end
    end

    // Adder drive comes only from the latched operation, never the live request.
    always_comb begin
        add_a_o     = r_acc_snap;
        add_b_o     = r_operand;
        add_carry_o = 1'b0;
        case (r_op_code)
            c_OP_ADC: add_carry_o = r_c;
`ifdef ALU_SUB_EN
            c_OP_SUB: begin
                add_b_o     = ~r_operand;
                add_carry_o = 1'b1;
            end
            c_OP_SBC: begin
                add_b_o     = ~r_operand;
                add_carry_o = r_c;
            end
`endif
            default: add_carry_o = 1'b0;
        endcase
    end

    assign acc_o    = r_acc;
    assign flag_c_o = r_c;
    assign flag_z_o = r_z;

endmodule
`default_nettype wire

// File: tb/tb_alu_accumulator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_alu_accumulator
// Description : Directed table-driven bench for alu_accumulator with an adder model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_accumulator;

    localparam logic [2:0] c_NOP = 3'b000;
    localparam logic [2:0] c_LDA = 3'b001;
    localparam logic [2:0] c_ADD = 3'b010;
    localparam logic [2:0] c_ADC = 3'b011;
    localparam logic [2:0] c_SUB = 3'b100;
    localparam logic [2:0] c_SBC = 3'b101;
    localparam logic [2:0] c_CLR = 3'b110;
    localparam logic [2:0] c_ILL = 3'b111;

    logic       clk;
    logic       rst_n;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] op_code;
    logic [3:0] operand;
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic       add_cin;
    logic [3:0] add_sum;
    logic       add_cout;
    logic [3:0] acc;
    logic       flag_c;
    logic       flag_z;
    logic       done;
    logic       err;

    int total = 0;
    int bad   = 0;

    alu_accumulator #(.DATA_W(4)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .op_valid_i  (op_valid),
        .op_ready_o  (op_ready),
        .op_code_i   (op_code),
        .operand_i   (operand),
        .add_a_o     (add_a),
        .add_b_o     (add_b),
        .add_carry_o (add_cin),
        .add_sum_i   (add_sum),
        .add_carry_i (add_cout),
        .acc_o       (acc),
        .flag_c_o    (flag_c),
        .flag_z_o    (flag_z),
        .done_o      (done),
        .err_o       (err)
    );

    // Behavioural stand-in for carry_ripple_adder.
    always_comb begin
        logic [4:0] w_full;
        w_full   = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
        add_sum  = w_full[3:0];
        add_cout = w_full[4];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] code;
        logic [3:0] opnd;
        logic [3:0] acc;
        logic       c;
        logic       z;
        logic       err;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge where ready comes back.
    task automatic run_op(input vec_t v, input int idx);
        int waited;
        waited = 0;
        while (!op_ready && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!op_ready) begin
            bad++;
            total++;
            $display("FAIL ready_timeout[%0d]: got 0 required 1", idx);
        end
        op_valid = 1'b1;
        op_code  = v.code;
        operand  = v.opnd;
        @(posedge clk); #1;
        op_valid = 1'b0;
        op_code  = c_ILL;
        operand  = ~v.opnd;
        check($sformatf("exec_done[%0d]", idx), {31'b0, done}, 32'd0);
        check($sformatf("exec_ready[%0d]", idx), {31'b0, op_ready}, 32'd0);
        @(posedge clk); #1;
        check($sformatf("done[%0d]", idx), {31'b0, done}, 32'd1);
        check($sformatf("err[%0d]", idx), {31'b0, err}, {31'b0, v.err});
        check($sformatf("acc[%0d]", idx), {28'b0, acc}, {28'b0, v.acc});
        check($sformatf("flag_c[%0d]", idx), {31'b0, flag_c}, {31'b0, v.c});
        check($sformatf("flag_z[%0d]", idx), {31'b0, flag_z}, {31'b0, v.z});
        @(posedge clk); #1;
        check($sformatf("done_clear[%0d]", idx), {31'b0, done}, 32'd0);
        check($sformatf("ready_back[%0d]", idx), {31'b0, op_ready}, 32'd1);
    endtask

    initial begin
        vecs[0]  = '{c_LDA, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{c_ADD, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{c_LDA, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{c_ADD, 4'h1, 4'h0, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{c_ADC, 4'h0, 4'h1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{c_LDA, 4'h9, 4'h9, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{c_ILL, 4'h7, 4'h9, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{c_NOP, 4'h3, 4'h9, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{c_ADC, 4'h7, 4'h0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{c_ADC, 4'h7, 4'h8, 1'b0, 1'b0, 1'b0};
`ifdef ALU_SUB_EN
        vecs[10] = '{c_SUB, 4'h5, 4'h3, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{c_LDA, 4'h5, 4'h5, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{c_SUB, 4'h5, 4'h0, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{c_LDA, 4'h3, 4'h3, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{c_SUB, 4'h5, 4'hE, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{c_SBC, 4'h1, 4'hC, 1'b1, 1'b0, 1'b0};
`else
        vecs[10] = '{c_SUB, 4'h5, 4'h8, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{c_LDA, 4'h5, 4'h5, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{c_SUB, 4'h5, 4'h5, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{c_LDA, 4'h3, 4'h3, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{c_SUB, 4'h5, 4'h3, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{c_SBC, 4'h1, 4'h3, 1'b0, 1'b0, 1'b1};
`endif

        rst_n    = 1'b0;
        op_valid = 1'b0;
        op_code  = c_NOP;
        operand  = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_acc",   {28'b0, acc},     32'd0);
        check("rst_c",     {31'b0, flag_c},  32'd0);
        check("rst_z",     {31'b0, flag_z},  32'd1);
        check("rst_ready", {31'b0, op_ready}, 32'd1);
        check("rst_done",  {31'b0, done},    32'd0);
        check("rst_err",   {31'b0, err},     32'd0);
        check("rst_add_a", {28'b0, add_a},   32'd0);
        check("rst_add_b", {28'b0, add_b},   32'd0);
        check("rst_add_c", {31'b0, add_cin}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i], i);
        end

        // CLR then hold an ADD 0x1 request continuously: one increment per 3 edges.
        run_op('{c_CLR, 4'h5, 4'h0, 1'b0, 1'b1, 1'b0}, 16);
        op_valid = 1'b1;
        op_code  = c_ADD;
        operand  = 4'h1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            check($sformatf("stream_acc[%0d]", i), {28'b0, acc}, (i + 1) / 3);
            check($sformatf("stream_done[%0d]", i), {31'b0, done}, ((i % 3) == 2) ? 32'd1 : 32'd0);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("stream_exec_ready", {31'b0, op_ready}, 32'd0);
        check("stream_exec_acc",   {28'b0, acc},      32'd3);

        // Reset while the fourth increment sits in EXEC.
        op_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        check("midrst_acc",   {28'b0, acc},      32'd0);
        check("midrst_done",  {31'b0, done},     32'd0);
        check("midrst_z",     {31'b0, flag_z},   32'd1);
        check("midrst_c",     {31'b0, flag_c},   32'd0);
        check("midrst_ready", {31'b0, op_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_done", {31'b0, done}, 32'd0);
        @(posedge clk); #1;
        check("postrst_done2", {31'b0, done}, 32'd0);
        check("postrst_acc",   {28'b0, acc},  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_accumulator.md
# alu_accumulator

Accumulator/sequencer stage wrapped around the carry-ripple adder of the 4-bit CPU datapath. It accepts one ALU operation per handshake and latches the opcode and operand. It drives the adder's operand and carry inputs, consumes the adder's sum and carry-out, and writes the result into the accumulator and the C/Z flag registers. It is the direct upstream feeder and downstream consumer of `carry_ripple_adder`. Port names map one-to-one onto the adder's `a_i`, `b_i`, `carry_i`, `sum_o` and `carry_o`.

## Interface
- `DATA_W`, default 4: datapath width. It must equal the adder's `CRA_BIT_NUMB`.

- `clk_i` in 1: the single clock. All state updates occur on its rising edge.
- `rst_n_i` in 1: reset, synchronous and active-low.
- `op_valid_i` in 1: an operation request is present.
- `op_ready_o` out 1: the block can accept an operation. High only in IDLE.
- `op_code_i` in 3: the opcode (see Operation).
- `operand_i` in DATA_W: operand B, or the load value.
- `add_a_o` out DATA_W: drives adder `a_i`.
- `add_b_o` out DATA_W: drives adder `b_i`.
- `add_carry_o` out 1: drives adder `carry_i`.
- `add_sum_i` in DATA_W: from adder `sum_o`.
- `add_carry_i` in 1: from adder `carry_o`.
- `acc_o` out DATA_W: the accumulator register.
- `flag_c_o` out 1: the carry flag (1 = carry out, or no borrow).
- `flag_z_o` out 1: the zero flag (1 = accumulator equals 0).
- `done_o` out 1: one-cycle completion pulse.
- `err_o` out 1: one-cycle pulse for an illegal opcode, coincident with `done_o`.

## Operation
- Opcodes:
  - 000 NOP: no change.
  - 001 LDA: acc = operand.
  - 010 ADD: acc = acc + operand, with carry-in 0.
  - 011 ADC: acc = acc + operand + C.
  - 100 SUB: acc = acc + ~operand + 1.
  - 101 SBC: acc = acc + ~operand + C.
  - 110 CLR: acc = 0 and C = 0.
  - 111: illegal.
- Adder drive:
  - `add_a_o` = latched acc snapshot.
  - `add_b_o` = latched operand, inverted for SUB/SBC.
  - `add_carry_o` = 0 for ADD, C for ADC/SBC, 1 for SUB.
  - All three are derived combinationally from the latched op registers only, never from live `op_*_i`.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: `op_ready_o` = 1. When `op_valid_i` & `op_ready_o`, latch the opcode and operand, then go to EXEC.
  - EXEC: adder inputs are stable. At the closing edge, write acc/C/Z per the opcode, then go to DONE.
  - DONE: `done_o` = 1, and `err_o` = 1 if the opcode was illegal. Go to IDLE unconditionally.
- Flag rules:
  - Arithmetic ops: C = `add_carry_i`.
  - LDA and NOP: C unchanged.
  - CLR: C = 0.
  - Z is recomputed from the new acc on every acc write.
  - NOP and illegal ops leave acc, C and Z untouched.
- Arithmetic wraps modulo 2^DATA_W. There is no overflow flag.
- `op_valid_i` asserted outside IDLE is ignored, not queued. The requester must hold it until `op_ready_o` is sampled high.

## Timing
- Reset values (asserted at a rising edge):
  - State = IDLE.
  - acc_o = 0, flag_c_o = 0, flag_z_o = 1.
  - done_o = 0, err_o = 0.
  - Latched op = NOP, so add_a_o = add_b_o = 0 and add_carry_o = 0.
  - op_ready_o = 1 from the first cycle after reset.
- Latency: handshake at edge k; acc and flags update at edge k+1; `done_o` is high for the cycle k+1..k+2; `op_ready_o` returns high after edge k+2.
- Throughput: one operation per 3 cycles. Back-to-back requests are accepted at edges k, k+3, k+6, and so on.
- The adder path is combinational within the EXEC cycle. No multicycle path is required.
- Reset mid-operation (in EXEC or DONE): the operation is discarded and no `done_o` is produced. All outputs take their reset values at that edge.

## Configuration
- `ALU_SUB_EN` defined: SUB and SBC are implemented as specified.
- `ALU_SUB_EN` undefined:
  - Opcodes 100 and 101 are treated exactly as 111: no state change, with `err_o` and `done_o` pulsed in DONE.
  - The `add_b_o` inversion logic is not built.

## Test plan
- Reset with `rst_n_i` = 0 for 2 cycles -> acc_o = 0x0, flag_c_o = 0, flag_z_o = 1, op_ready_o = 1, done_o = 0.
- LDA 0x1, then ADD 0x2 -> acc_o = 0x3, C = 0, Z = 0. `done_o` is high exactly 2 edges after each handshake.
- LDA 0xF, ADD 0x1 -> acc = 0x0, C = 1, Z = 1. Then ADC 0x0 -> acc = 0x1, C = 0, Z = 0.
- With `ALU_SUB_EN`:
  - LDA 0x5, SUB 0x5 -> acc = 0x0, C = 1, Z = 1.
  - LDA 0x3, SUB 0x5 -> acc = 0xE, C = 0.
  - Without `ALU_SUB_EN`, SUB 0x5 -> err_o = 1 and acc is unchanged.
- Opcode 111 with operand 0x7 after LDA 0x9 -> done_o = err_o = 1 for one cycle, and acc stays 0x9.
- `op_valid_i` held high continuously with ADD 0x1 from acc = 0 -> acc increments at edges spaced 3 cycles apart. Then drive `rst_n_i` = 0 during EXEC -> no done_o, and acc = 0 at the next edge.
